fft_bitrev_buffer: RTL and testbench

Ping-pong input buffer that sits directly upstream of the first radix-2 `butterfly` stage of the FFT datapath. It accepts complex samples in natural order over a valid/ready stream and stores one N-point frame per bank. It emits the frame as bit-reversed butterfly input pairs (`a`, `b`), one pair per cycle, so stage 0 can consume them directly. While one bank drains, the other fills, giving full-rate streaming.

---
 rtl/fft_bitrev_buffer.sv | 122 ++++++++++++
 tb/tb_fft_bitrev_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer: natural-order complex samples in, bit-reversed radix-2 butterfly pairs out.
// Build macro FFT_BITREV_PREHALVE_EN stores every component as (in >>> 1) to give one bit of headroom.
//
// Per-bank life cycle (derived from r_full and the bank pointers, no separate state register):
//   state    | meaning
//   EMPTY    | not the write bank, full clear
//   FILLING  | write bank, full clear, accepting samples
//   FULL     | full set, waiting to become the read bank
//   DRAINING | read bank, full set, emitting pairs
module fft_bitrev_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_LOG2     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0][DATA_WIDTH-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0] out_a_o,
    output logic [1:0][DATA_WIDTH-1:0] out_b_o,
    output logic                       out_last_o
);
    localparam int N    = 1 << N_LOG2;
    localparam int RD_W = N_LOG2 - 1;
    localparam logic [N_LOG2-1:0] WR_LAST = '1;
    localparam logic [RD_W-1:0]   RD_LAST = '1;

    logic [1:0][DATA_WIDTH-1:0] r_mem [2][N];
    logic                       r_wr_bank;
    logic                       r_rd_bank;
    logic [N_LOG2-1:0]          r_wr_ptr;
    logic [RD_W-1:0]            r_rd_ptr;
    logic [1:0]                 r_full;

    logic                       w_wr_fire;
    logic                       w_wr_done;
    logic                       w_rd_fire;
    logic                       w_rd_done;
    logic [1:0]                 w_full_set;
    logic [1:0]                 w_full_clr;
    logic [N_LOG2-1:0]          w_idx_a;
    logic [N_LOG2-1:0]          w_idx_b;
    logic [1:0][DATA_WIDTH-1:0] w_wdata;

    function automatic logic [N_LOG2-1:0] f_bitrev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] y;
        y = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            y[i] = x[N_LOG2-1-i];
        end
        return y;
    endfunction

    always_comb begin
        for (int c = 0; c < 2; c++) begin
`ifdef FFT_BITREV_PREHALVE_EN
            w_wdata[c] = $signed(in_data_i[c]) >>> 1;
`else
            w_wdata[c] = in_data_i[c];
`endif
        end
    end

    assign in_ready_o  = !r_full[r_wr_bank];
    assign out_valid_o = r_full[r_rd_bank];

    assign w_wr_fire = in_valid_i && in_ready_o;
    assign w_wr_done = w_wr_fire && (r_wr_ptr == WR_LAST);
    assign w_rd_fire = out_valid_o && out_ready_i;
    assign w_rd_done = w_rd_fire && (r_rd_ptr == RD_LAST);

    // bitrev of an even index always has a clear MSB, so its partner is the same index plus N/2
    assign w_idx_a = f_bitrev({r_rd_ptr, 1'b0});
    assign w_idx_b = {1'b1, w_idx_a[N_LOG2-2:0]};

    assign out_a_o    = r_mem[r_rd_bank][w_idx_a];
    assign out_b_o    = r_mem[r_rd_bank][w_idx_b];
    assign out_last_o = out_valid_o && (r_rd_ptr == RD_LAST);

    assign w_full_set = {r_wr_bank, !r_wr_bank} & {2{w_wr_done}};
    assign w_full_clr = {r_rd_bank, !r_rd_bank} & {2{w_rd_done}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    r_mem[b][k] <= '0;
                end
            end
        end else if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_ptr] <= w_wdata;
        end
    end

    // Set and clear never target the same bank: the writer only fills a bank whose full bit is clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_full    <= '0;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_wr_done) begin
                r_wr_bank <= !r_wr_bank;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_rd_done) begin
                r_rd_bank <= !r_rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Directed and random-stall bench for fft_bitrev_buffer (N=16) with a bit-reversal scoreboard.
module tb_fft_bitrev_buffer;
    localparam int DW = 16;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [1:0][DW-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0][DW-1:0] out_a;
    logic [1:0][DW-1:0] out_b;
    logic             out_last;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_pairs = 0;

    always #5 clk = ~clk;

    fft_bitrev_buffer #(.DATA_WIDTH(DW), .N_LOG2(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_a_o     (out_a),
        .out_b_o     (out_b),
        .out_last_o  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] st(input logic [DW-1:0] x);
`ifdef FFT_BITREV_PREHALVE_EN
        return DW'($signed(x) >>> 1);
`else
        return x;
`endif
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // scoreboard: collects accepted samples per frame, expects pairs (rev(2j), rev(2j+1))
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
    } pair_t;

    pair_t       exp_q[$];
    pair_t       sb_p;
    logic [31:0] fbuf [16];
    int          fcnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            fcnt = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_pair", {31'd0, out_valid}, 32'd0);
                end else begin
                    sb_p = exp_q.pop_front();
                    check("sb_a", out_a, sb_p.a);
                    check("sb_b", out_b, sb_p.b);
                    check("sb_last", {31'd0, out_last}, {31'd0, sb_p.last});
                    n_pairs++;
                end
            end
            if (in_valid && in_ready) begin
                fbuf[fcnt] = {st(in_data[1]), st(in_data[0])};
                fcnt++;
                if (fcnt == 16) begin
                    for (int j = 0; j < 8; j++) begin
                        sb_p.a    = fbuf[rev4(4'(2 * j))];
                        sb_p.b    = fbuf[rev4(4'(2 * j + 1))];
                        sb_p.last = (j == 7);
                        exp_q.push_back(sb_p);
                    end
                    fcnt = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while ((out_valid || exp_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", {31'd0, k < 200}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] br_tab [8] = '{4'd0, 4'd4, 4'd2, 4'd6, 4'd1, 4'd5, 4'd3, 4'd7};

    initial begin
        int p0;
        int b;
        int sent;
        int cycles;
        logic acc;

        // reset held from time 0
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // bit-reverse order: re=k, im=-k
        p0 = n_pairs;
        for (int k = 0; k < 16; k++) begin
            in_valid   = 1'b1;
            in_data[0] = 16'(k);
            in_data[1] = 16'(-k);
            @(negedge clk);
            check("t1_in_ready", {31'd0, in_ready}, 32'd1);
            check("t1_valid_early", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            b = int'(br_tab[j]);
            @(negedge clk);
            check("t1_valid", {31'd0, out_valid}, 32'd1);
            check("t1_a", out_a, {st(16'(-b)), st(16'(b))});
            check("t1_b", out_b, {st(16'(-(b + 8))), st(16'(b + 8))});
            check("t1_last", {31'd0, out_last}, {31'd0, j == 7});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t1_valid_after", {31'd0, out_valid}, 32'd0);
        check("t1_pairs", n_pairs - p0, 32'd8);
        @(posedge clk);
        #1;

        // back-to-back: 4 frames, continuous input
        p0 = n_pairs;
        for (int i = 0; i < 64; i++) begin
            in_valid   = 1'b1;
            in_data[0] = 16'(100 + i);
            in_data[1] = 16'(3 * i);
            @(negedge clk);
            check("t2_in_ready", {31'd0, in_ready}, 32'd1);
            check("t2_out_valid", {31'd0, out_valid}, {31'd0, (i >= 16) && (i % 16 < 8)});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("t2_pairs", n_pairs - p0, 32'd32);

        // backpressure: 40 offered samples with out_ready low
        do_reset();
        out_ready = 1'b0;
        p0 = n_pairs;
        for (int i = 0; i < 40; i++) begin
            in_valid   = 1'b1;
            in_data[0] = 16'(i < 32 ? i : 32);
            in_data[1] = 16'(1000 + (i < 32 ? i : 32));
            @(negedge clk);
            check("t3_in_ready", {31'd0, in_ready}, {31'd0, i < 32});
            if (i >= 16) begin
                check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
                check("t3_hold_a", out_a, {st(16'd1000), st(16'd0)});
                check("t3_hold_b", out_b, {st(16'd1008), st(16'd8)});
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            b = int'(br_tab[j]);
            @(negedge clk);
            check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
            check("t3_drain_a", out_a, {st(16'(1000 + b)), st(16'(b))});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t3_ready_rise", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 33; i < 48; i++) begin
            in_data[0] = 16'(i);
            in_data[1] = 16'(1000 + i);
            @(negedge clk);
            check("t3_refill_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("t3_pairs", n_pairs - p0, 32'd24);

        // reset mid-frame after 9 samples, then a fresh frame
        for (int i = 0; i < 9; i++) begin
            in_valid   = 1'b1;
            in_data[0] = 16'(500 + i);
            in_data[1] = 16'(i);
            @(posedge clk);
            #1;
        end
        do_reset();
        p0 = n_pairs;
        for (int k = 0; k < 16; k++) begin
            in_valid   = 1'b1;
            in_data[0] = 16'(200 + k);
            in_data[1] = 16'(2 * k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_valid", {31'd0, out_valid}, 32'd1);
        check("t4_a", out_a, {st(16'd0), st(16'd200)});
        check("t4_b", out_b, {st(16'd16), st(16'd208)});
        drain();
        check("t4_pairs", n_pairs - p0, 32'd8);

        // prehalve: sample 0 = (-3, 5), sample 8 = (-1, 1)
        for (int k = 0; k < 16; k++) begin
            in_valid   = 1'b1;
            in_data[0] = (k == 0) ? 16'hFFFD : (k == 8) ? 16'hFFFF : 16'(k);
            in_data[1] = (k == 0) ? 16'd5 : (k == 8) ? 16'd1 : 16'd0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
`ifdef FFT_BITREV_PREHALVE_EN
        check("t5_a", out_a, {16'd2, 16'hFFFE});
        check("t5_b", out_b, {16'd0, 16'hFFFF});
`else
        check("t5_a", out_a, {16'd5, 16'hFFFD});
        check("t5_b", out_b, {16'd1, 16'hFFFF});
`endif
        drain();

        // random stall: 100 frames
        p0     = n_pairs;
        sent   = 0;
        cycles = 0;
        while (sent < 1600 && cycles < 20000) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data[0] = 16'(sent * 7);
            in_data[1] = 16'(~sent);
            out_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cycles++;
        end
        check("t6_timeout", {31'd0, cycles < 20000}, 32'd1);
        in_valid = 1'b0;
        drain();
        check("t6_pairs", n_pairs - p0, 32'd800);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
